noc_rsc_injector: RTL and testbench

//  Resource-side network interface (TX) between one processing element and its mesh_xy_noc resource input channel.
//  - Accepts (data, dst_row, dst_col) over a valid/ready handshake.
//  - Buffers requests in a FIFO and formats them as NoC packets.
//  - Writes packets into the NoC only while the router's full flag is low.
//  - Drops illegal destinations, counts traffic and latches router overflow.

---
 rtl/noc_rsc_injector.sv | 164 ++++++++++++++++
 tb/tb_noc_rsc_injector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_rsc_injector.sv
`default_nettype none
// ============================================================================
//  Module   : noc_rsc_injector
//  Brief    : Resource-side NoC TX interface. Buffers (data, row, col) requests
//             in a FIFO and writes them as {row, col, data} packets into the
//             router while its full flag is low.
//  Revision : 1.0  initial release
// ============================================================================
module noc_rsc_injector #(
    parameter  int ROW_N        = 3,
    parameter  int COL_M        = 3,
    parameter  int PCKT_DATA_W  = 8,
    parameter  int FIFO_DEPTH_W = 3,
    parameter  int CNT_W        = 16,
    localparam int ROW_W        = $clog2(ROW_N),
    localparam int COL_W        = $clog2(COL_M),
    localparam int PACKET_W     = PCKT_DATA_W + ROW_W + COL_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PCKT_DATA_W-1:0] rsc_data_i,
    input  logic [ROW_W-1:0]       rsc_dst_row_i,
    input  logic [COL_W-1:0]       rsc_dst_col_i,
    input  logic                   rsc_valid_i,
    output logic                   rsc_ready_o,
    output logic [PACKET_W-1:0]    noc_pckt_o,
    output logic                   noc_wren_o,
    input  logic                   noc_full_i,
    input  logic                   noc_ovrflw_i,
    output logic [CNT_W-1:0]       sent_cnt_o,
    output logic [CNT_W-1:0]       drop_cnt_o,
    output logic                   ovrflw_err_o,
    output logic [1:0]             state_o
);

    localparam logic [FIFO_DEPTH_W:0]   c_depth   = {1'b1, {FIFO_DEPTH_W{1'b0}}};
    localparam logic [FIFO_DEPTH_W:0]   c_cnt_one = 1;
    localparam logic [FIFO_DEPTH_W-1:0] c_ptr_one = 1;
    localparam logic [ROW_W:0]          c_row_lim = ROW_N[ROW_W:0];
    localparam logic [COL_W:0]          c_col_lim = COL_M[COL_W:0];
    localparam logic [CNT_W-1:0]        c_cnt_max = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    logic [PACKET_W-1:0]     r_mem [0:(2**FIFO_DEPTH_W)-1];
    logic [FIFO_DEPTH_W-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_W-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_W:0]   r_count;
    logic [PACKET_W-1:0]     r_head;
    logic [CNT_W-1:0]        r_sent_cnt;
    logic [CNT_W-1:0]        r_drop_cnt;
    logic                    r_ovrflw_err;
    state_t                  r_state;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_hs;
    logic                    w_legal;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_pop;
    logic [PACKET_W-1:0]     w_pkt_in;
    logic [FIFO_DEPTH_W-1:0] w_rd_ptr_inc;
    logic [FIFO_DEPTH_W:0]   w_count_next;
    logic [PACKET_W-1:0]     w_head_next;
    state_t                  w_state_next;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_depth);
    assign rsc_ready_o  = ~w_full;
    assign w_hs         = rsc_valid_i & rsc_ready_o;
    assign w_legal      = ({1'b0, rsc_dst_row_i} < c_row_lim) & ({1'b0, rsc_dst_col_i} < c_col_lim);
    assign w_push       = w_hs & w_legal;
    assign w_drop       = w_hs & ~w_legal;
    assign noc_wren_o   = ~w_empty & ~noc_full_i & ~rst_i;
    assign w_pop        = noc_wren_o;
    assign w_pkt_in     = {rsc_dst_row_i, rsc_dst_col_i, rsc_data_i};
    assign w_rd_ptr_inc = r_rd_ptr + c_ptr_one;
    assign w_count_next = r_count + {{FIFO_DEPTH_W{1'b0}}, w_push} - {{FIFO_DEPTH_W{1'b0}}, w_pop};

    // The head register tracks the post-edge FIFO head so the packet is valid
    // in the same cycle wren first rises; a push into an empty (or draining
    // to empty) FIFO bypasses the memory.
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_count == c_cnt_one) begin
                if (w_push) begin
                    w_head_next = w_pkt_in;
                end
            end else begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end
        end else if (w_push && w_empty) begin
            w_head_next = w_pkt_in;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_count_next != '0) w_state_next = S_SEND;
            S_SEND: begin
                if (w_count_next == '0) begin
                    w_state_next = S_IDLE;
                end else if (noc_full_i) begin
                    w_state_next = S_STALL;
                end
            end
            S_STALL: if (!noc_full_i) w_state_next = S_SEND;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pkt_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_sent_cnt   <= '0;
            r_drop_cnt   <= '0;
            r_ovrflw_err <= 1'b0;
            r_state      <= S_IDLE;
        end else begin
            r_count <= w_count_next;
            r_head  <= w_head_next;
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_pop && (r_sent_cnt != c_cnt_max)) begin
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != c_cnt_max)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (noc_ovrflw_i) begin
                r_ovrflw_err <= 1'b1;
            end
        end
    end

    assign noc_pckt_o   = r_head;
    assign sent_cnt_o   = r_sent_cnt;
    assign drop_cnt_o   = r_drop_cnt;
    assign ovrflw_err_o = r_ovrflw_err;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_noc_rsc_injector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_rsc_injector
//  Brief    : Directed self-checking bench for noc_rsc_injector (3x3 mesh).
//  Revision : 1.0  initial release
// ============================================================================
module tb_noc_rsc_injector;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rsc_data_i;
    logic [1:0]  rsc_dst_row_i;
    logic [1:0]  rsc_dst_col_i;
    logic        rsc_valid_i;
    logic        rsc_ready_o;
    logic [11:0] noc_pckt_o;
    logic        noc_wren_o;
    logic        noc_full_i;
    logic        noc_ovrflw_i;
    logic [15:0] sent_cnt_o;
    logic [15:0] drop_cnt_o;
    logic        ovrflw_err_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    noc_rsc_injector dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rsc_data_i    (rsc_data_i),
        .rsc_dst_row_i (rsc_dst_row_i),
        .rsc_dst_col_i (rsc_dst_col_i),
        .rsc_valid_i   (rsc_valid_i),
        .rsc_ready_o   (rsc_ready_o),
        .noc_pckt_o    (noc_pckt_o),
        .noc_wren_o    (noc_wren_o),
        .noc_full_i    (noc_full_i),
        .noc_ovrflw_i  (noc_ovrflw_i),
        .sent_cnt_o    (sent_cnt_o),
        .drop_cnt_o    (drop_cnt_o),
        .ovrflw_err_o  (ovrflw_err_o),
        .state_o       (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] r, input logic [1:0] c);
        rsc_data_i    = d;
        rsc_dst_row_i = r;
        rsc_dst_col_i = c;
        rsc_valid_i   = 1'b1;
        tick();
        rsc_valid_i   = 1'b0;
    endtask

    logic [11:0] exp_q [8];
    int          k;

    initial begin
        rst_i = 1'b1; rsc_valid_i = 1'b0; rsc_data_i = '0;
        rsc_dst_row_i = '0; rsc_dst_col_i = '0; noc_full_i = 1'b0; noc_ovrflw_i = 1'b0;
        tick(); tick();
        check("rst_ready", rsc_ready_o, 1);
        check("rst_wren",  noc_wren_o, 0);
        check("rst_pckt",  noc_pckt_o, 0);
        check("rst_state", state_o, 0);
        check("rst_sent",  sent_cnt_o, 0);
        check("rst_drop",  drop_cnt_o, 0);
        check("rst_err",   ovrflw_err_o, 0);
        rst_i = 1'b0;
        #1;

        // Single packet, one-cycle latency
        push(8'hA5, 2'd2, 2'd1);
        #1;
        check("t1_wren",  noc_wren_o, 1);
        check("t1_pckt",  noc_pckt_o, 12'h9A5);
        check("t1_state", state_o, 1);
        check("t1_sent0", sent_cnt_o, 0);
        tick();
        check("t1_sent1", sent_cnt_o, 1);
        check("t1_wren0", noc_wren_o, 0);
        check("t1_idle",  state_o, 0);
        check("t1_hold",  noc_pckt_o, 12'h9A5);

        // Burst of 8 into a blocked router
        noc_full_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q[i] = {2'(i % 3), 2'((i + 2) % 3), 8'(8'h10 + i)};
            check("t2_ready_hi", rsc_ready_o, 1);
            push(8'(8'h10 + i), 2'(i % 3), 2'((i + 2) % 3));
            check("t2_no_wren", noc_wren_o, 0);
        end
        #1;
        check("t2_ready_lo", rsc_ready_o, 0);
        check("t2_stall",    state_o, 2);
        check("t2_sent",     sent_cnt_o, 1);
        noc_full_i = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("t2_drain_wren", noc_wren_o, 1);
            check("t2_drain_pckt", noc_pckt_o, exp_q[i]);
            tick();
        end
        check("t2_done_wren", noc_wren_o, 0);
        check("t2_done_sent", sent_cnt_o, 9);
        check("t2_done_idle", state_o, 0);
        check("t2_done_rdy",  rsc_ready_o, 1);

        // Drain of 5 with full toggling every cycle
        noc_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q[i] = {2'd1, 2'(i % 3), 8'(8'h30 + i)};
            push(8'(8'h30 + i), 2'd1, 2'(i % 3));
        end
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            noc_full_i = (c % 2 == 0);
            #1;
            if (noc_full_i) begin
                check("t3_blocked", noc_wren_o, 0);
            end else begin
                check("t3_wren", noc_wren_o, 1);
                check("t3_pckt", noc_pckt_o, exp_q[k]);
                k++;
            end
            tick();
        end
        check("t3_delivered", k, 5);
        check("t3_sent", sent_cnt_o, 14);
        noc_full_i = 1'b0;

        // Illegal destinations are consumed and counted
        #1;
        check("t4_ready", rsc_ready_o, 1);
        push(8'h77, 2'd3, 2'd0);
        #1;
        check("t4_drop1", drop_cnt_o, 1);
        check("t4_nowren", noc_wren_o, 0);
        check("t4_idle", state_o, 0);
        push(8'h66, 2'd0, 2'd3);
        #1;
        check("t4_drop2", drop_cnt_o, 2);
        check("t4_nowren2", noc_wren_o, 0);
        push(8'h5C, 2'd0, 2'd2);
        #1;
        check("t4_legal_wren", noc_wren_o, 1);
        check("t4_legal_pckt", noc_pckt_o, 12'h25C);
        tick();
        check("t4_sent", sent_cnt_o, 15);
        check("t4_drop_keep", drop_cnt_o, 2);

        // Sticky overflow flag
        check("t5_err0", ovrflw_err_o, 0);
        noc_ovrflw_i = 1'b1;
        tick();
        noc_ovrflw_i = 1'b0;
        check("t5_err1", ovrflw_err_o, 1);
        tick(); tick(); tick();
        check("t5_sticky", ovrflw_err_o, 1);

        // Reset with packets queued behind a full router
        noc_full_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h40 + i), 2'd2, 2'd2);
        end
        #1;
        check("t6_stall", state_o, 2);
        rst_i = 1'b1;
        #1;
        check("t6_wren_in_rst", noc_wren_o, 0);
        tick();
        check("t6_wren",  noc_wren_o, 0);
        check("t6_ready", rsc_ready_o, 1);
        check("t6_sent",  sent_cnt_o, 0);
        check("t6_drop",  drop_cnt_o, 0);
        check("t6_err",   ovrflw_err_o, 0);
        check("t6_state", state_o, 0);
        check("t6_pckt",  noc_pckt_o, 0);
        rst_i = 1'b0;
        noc_full_i = 1'b0;
        #1;
        check("t6_flushed", noc_wren_o, 0);
        tick();
        check("t6_still_empty", noc_wren_o, 0);
        check("t6_sent_after", sent_cnt_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
